// File: rtl/pmu_pkg.sv
// Shared types and defaults for the wake-up power management unit.
// Holds FSM state encoding, low-power mode codes and default sizing.
package pmu_pkg;

   localparam int GATE_DLY_DEF = 4;
   localparam int CNT_W_DEF    = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_SLEEP   = 3'd2,
      ST_WAKE    = 3'd3,
      ST_RELEASE = 3'd4
   } pmu_st_e;

   localparam logic [1:0] LPMD_WAIT = 2'b00;
   localparam logic [1:0] LPMD_DOZE = 2'b01;
   localparam logic [1:0] LPMD_STOP = 2'b10;

   // 10 and 11 both mean STOP
   function automatic logic lpmd_is_stop(input logic [1:0] md);
      return md[1];
   endfunction

endpackage

// File: rtl/pmu_dn_cnt.sv
// Loadable down-counter with zero flag; holds at zero, never wraps.
// Ports: wic_clk, pad_cpu_rst_b, cnt_ld/cnt_ld_val, cnt_dec, cnt_zero.
module pmu_dn_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             wic_clk,
   input  logic             pad_cpu_rst_b,
   input  logic             cnt_ld,
   input  logic [CNT_W-1:0] cnt_ld_val,
   input  logic             cnt_dec,
   output logic             cnt_zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         cnt_q <= '0;
      end else if (cnt_ld) begin
         cnt_q <= cnt_ld_val;
      end else if (cnt_dec && !cnt_zero) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/pmu_wake_ctrl.sv
// Low-power sequencer: gates clocks on CPU sleep request, reopens on wake.
// In: wic_clk, pad_cpu_rst_b, cpu_pmu_sleep_req, cpu_pmu_lpmd, intraw_vld,
//     pmu_wake_cnt_cfg. Out: clock enables, osc_pd, wakeup pulse, status.
import pmu_pkg::*;

module pmu_wake_ctrl #(
   parameter int GATE_DLY = GATE_DLY_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             wic_clk,
   input  logic             pad_cpu_rst_b,
   input  logic             cpu_pmu_sleep_req,
   input  logic [1:0]       cpu_pmu_lpmd,
   input  logic             intraw_vld,
   input  logic [CNT_W-1:0] pmu_wake_cnt_cfg,
   output logic             pmu_cpu_clk_en,
   output logic             pmu_periph_clk_en,
   output logic             pmu_osc_pd,
   output logic             pmu_cpu_wakeup,
   output logic             pmu_sleep_st,
   output logic [1:0]       pmu_lpmd_st
);

   pmu_st_e          st_q;
   pmu_st_e          st_nxt;
   logic [1:0]       lpmd_nxt;
   logic             stop_nxt;
   logic             gated_nxt;
   logic             cnt_ld;
   logic [CNT_W-1:0] cnt_ld_val;
   logic             cnt_dec;
   logic             cnt_zero;

   pmu_dn_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .wic_clk       (wic_clk),
      .pad_cpu_rst_b (pad_cpu_rst_b),
      .cnt_ld        (cnt_ld),
      .cnt_ld_val    (cnt_ld_val),
      .cnt_dec       (cnt_dec),
      .cnt_zero      (cnt_zero)
   );

   always_comb begin
      st_nxt     = st_q;
      cnt_ld     = 1'b0;
      cnt_ld_val = '0;
      cnt_dec    = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (cpu_pmu_sleep_req) begin
               if (intraw_vld) begin
                  st_nxt = ST_RELEASE;
               end else begin
                  st_nxt     = ST_DRAIN;
                  cnt_ld     = 1'b1;
                  cnt_ld_val = CNT_W'(GATE_DLY - 1);
               end
            end
         end
         ST_DRAIN: begin
            if (intraw_vld) begin
               st_nxt = ST_RELEASE;
            end else if (cnt_zero) begin
               st_nxt = ST_SLEEP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_SLEEP: begin
            if (intraw_vld) begin
               st_nxt = ST_WAKE;
               cnt_ld = 1'b1;
               // only STOP needs oscillator settle time
               cnt_ld_val = lpmd_is_stop(pmu_lpmd_st) ?
                            pmu_wake_cnt_cfg : '0;
            end
         end
         ST_WAKE: begin
            if (cnt_zero) begin
               st_nxt = ST_RELEASE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!cpu_pmu_sleep_req) begin
               st_nxt = ST_IDLE;
            end
         end
         default: st_nxt = ST_IDLE;
      endcase
   end

   // mode is captured once on DRAIN entry, ignored afterwards
   assign lpmd_nxt  = (st_q == ST_IDLE && st_nxt == ST_DRAIN) ?
                      cpu_pmu_lpmd : pmu_lpmd_st;
   assign stop_nxt  = lpmd_is_stop(lpmd_nxt);
   assign gated_nxt = (st_nxt == ST_SLEEP) || (st_nxt == ST_WAKE);

   always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         st_q              <= ST_IDLE;
         pmu_cpu_clk_en    <= 1'b1;
         pmu_periph_clk_en <= 1'b1;
         pmu_osc_pd        <= 1'b0;
         pmu_cpu_wakeup    <= 1'b0;
         pmu_sleep_st      <= 1'b0;
         pmu_lpmd_st       <= LPMD_WAIT;
      end else begin
         st_q              <= st_nxt;
         pmu_cpu_clk_en    <= !gated_nxt;
         pmu_periph_clk_en <= !(gated_nxt && stop_nxt);
         pmu_osc_pd        <= (st_nxt == ST_SLEEP) && stop_nxt;
         pmu_cpu_wakeup    <= (st_nxt == ST_RELEASE) &&
                              (st_q != ST_RELEASE);
         pmu_sleep_st      <= (st_nxt == ST_SLEEP);
         pmu_lpmd_st       <= lpmd_nxt;
      end
   end

endmodule

// File: tb/tb_pmu_wake_ctrl.sv
// Self-checking bench for pmu_wake_ctrl: directed scenarios plus random.
// Expected outputs come from a deadline-based behavioural model.
module tb_pmu_wake_ctrl;

   localparam int GD = 4;

   localparam int P_IDLE  = 0;
   localparam int P_DRAIN = 1;
   localparam int P_SLEEP = 2;
   localparam int P_WAKE  = 3;
   localparam int P_REL   = 4;

   logic       wic_clk = 1'b0;
   logic       pad_cpu_rst_b;
   logic       req;
   logic [1:0] lpmd;
   logic       irq;
   logic [7:0] cfg;
   logic       pmu_cpu_clk_en;
   logic       pmu_periph_clk_en;
   logic       pmu_osc_pd;
   logic       pmu_cpu_wakeup;
   logic       pmu_sleep_st;
   logic [1:0] pmu_lpmd_st;

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;

   int         ph;
   int         t_sleep;
   int         t_rel;
   logic [1:0] m_lpmd;
   logic       m_pulse;

   int gate_cyc;
   int wake_cyc;
   int wake_cnt;
   int sleep_seen;

   pmu_wake_ctrl #(
      .GATE_DLY (GD),
      .CNT_W    (8)
   ) dut (
      .wic_clk           (wic_clk),
      .pad_cpu_rst_b     (pad_cpu_rst_b),
      .cpu_pmu_sleep_req (req),
      .cpu_pmu_lpmd      (lpmd),
      .intraw_vld        (irq),
      .pmu_wake_cnt_cfg  (cfg),
      .pmu_cpu_clk_en    (pmu_cpu_clk_en),
      .pmu_periph_clk_en (pmu_periph_clk_en),
      .pmu_osc_pd        (pmu_osc_pd),
      .pmu_cpu_wakeup    (pmu_cpu_wakeup),
      .pmu_sleep_st      (pmu_sleep_st),
      .pmu_lpmd_st       (pmu_lpmd_st)
   );

   always #5 wic_clk = ~wic_clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ph      = P_IDLE;
      m_lpmd  = 2'b00;
      m_pulse = 1'b0;
      t_sleep = 0;
      t_rel   = 0;
   endtask

   // Inputs of cycle cyc decide the model's view of cycle cyc+1.
   task automatic model_edge();
      int n;
      n       = cyc + 1;
      m_pulse = 1'b0;
      case (ph)
         P_IDLE: begin
            if (req && irq) begin
               ph      = P_REL;
               m_pulse = 1'b1;
            end else if (req) begin
               ph      = P_DRAIN;
               m_lpmd  = lpmd;
               t_sleep = n + GD;
            end
         end
         P_DRAIN: begin
            if (irq) begin
               ph      = P_REL;
               m_pulse = 1'b1;
            end else if (n == t_sleep) begin
               ph = P_SLEEP;
            end
         end
         P_SLEEP: begin
            if (irq) begin
               ph    = P_WAKE;
               t_rel = cyc + 2 + (m_lpmd[1] ? int'(cfg) : 0);
            end
         end
         P_WAKE: begin
            if (n == t_rel) begin
               ph      = P_REL;
               m_pulse = 1'b1;
            end
         end
         P_REL: begin
            if (!req) ph = P_IDLE;
         end
         default: ph = P_IDLE;
      endcase
   endtask

   task automatic step();
      logic gated;
      logic stp;
      @(posedge wic_clk);
      model_edge();
      #1;
      cyc++;
      gated = (ph == P_SLEEP) || (ph == P_WAKE);
      stp   = m_lpmd[1];
      check("cpu_clk_en", 32'(pmu_cpu_clk_en), 32'(!gated));
      check("periph_clk_en", 32'(pmu_periph_clk_en),
            32'(!(gated && stp)));
      check("osc_pd", 32'(pmu_osc_pd), 32'((ph == P_SLEEP) && stp));
      check("wakeup", 32'(pmu_cpu_wakeup), 32'(m_pulse));
      check("sleep_st", 32'(pmu_sleep_st), 32'(ph == P_SLEEP));
      check("lpmd_st", 32'(pmu_lpmd_st), 32'(m_lpmd));
      if (pmu_cpu_clk_en === 1'b0 && gate_cyc < 0) gate_cyc = cyc;
      if (pmu_cpu_wakeup === 1'b1) begin
         wake_cnt++;
         if (wake_cyc < 0) wake_cyc = cyc;
      end
      if (pmu_sleep_st === 1'b1) sleep_seen = 1;
   endtask

   task automatic clr_track();
      gate_cyc   = -1;
      wake_cyc   = -1;
      wake_cnt   = 0;
      sleep_seen = 0;
   endtask

   // req raised at cycle 0, irq pulse at irq_at, req held to cyc_end
   task automatic scenario(input logic [1:0] md, input logic [7:0] cf,
                           input int irq_at, input int cyc_end);
      cfg = cf;
      lpmd = md;
      cyc = 0;
      clr_track();
      req = 1'b1;
      while (cyc < cyc_end) begin
         irq = (cyc == irq_at);
         step();
         lpmd = ~md;
      end
      irq = 1'b0;
   endtask

   task automatic drop_req();
      req = 1'b0;
      step();
      step();
   endtask

   initial begin
      req  = 1'b0;
      irq  = 1'b0;
      lpmd = 2'b00;
      cfg  = 8'd0;
      pad_cpu_rst_b = 1'b1;
      model_reset();
      clr_track();
      #3 pad_cpu_rst_b = 1'b0;
      #1;
      check("rst_cpu_clk_en", 32'(pmu_cpu_clk_en), 32'd1);
      check("rst_periph_clk_en", 32'(pmu_periph_clk_en), 32'd1);
      check("rst_osc_pd", 32'(pmu_osc_pd), 32'd0);
      check("rst_wakeup", 32'(pmu_cpu_wakeup), 32'd0);
      check("rst_sleep_st", 32'(pmu_sleep_st), 32'd0);
      check("rst_lpmd_st", 32'(pmu_lpmd_st), 32'd0);
      repeat (2) @(posedge wic_clk);
      @(negedge wic_clk);
      pad_cpu_rst_b = 1'b1;
      repeat (3) step();

      scenario(2'b00, 8'd0, 10, 12);
      check("wait_gate_cyc", 32'(gate_cyc), 32'd5);
      check("wait_wake_cyc", 32'(wake_cyc), 32'd12);
      drop_req();

      scenario(2'b10, 8'd16, 10, 28);
      check("stop_gate_cyc", 32'(gate_cyc), 32'd5);
      check("stop_wake_cyc", 32'(wake_cyc), 32'd28);
      check("stop_lpmd_st", 32'(pmu_lpmd_st), 32'd2);
      drop_req();

      scenario(2'b11, 8'd0, 10, 13);
      check("stop0_wake_cyc", 32'(wake_cyc), 32'd12);
      drop_req();

      scenario(2'b00, 8'd0, 3, 8);
      check("abort_gate_cyc", 32'(gate_cyc), 32'hffffffff);
      check("abort_wake_cyc", 32'(wake_cyc), 32'd4);
      check("abort_sleep_seen", 32'(sleep_seen), 32'd0);
      drop_req();

      scenario(2'b01, 8'd0, 0, 4);
      check("simul_wake_cyc", 32'(wake_cyc), 32'd1);
      check("simul_gate_cyc", 32'(gate_cyc), 32'hffffffff);
      drop_req();

      scenario(2'b01, 8'd5, 10, 25);
      check("held_wake_cnt", 32'(wake_cnt), 32'd1);
      check("held_wake_cyc", 32'(wake_cyc), 32'd12);
      check("held_doze_periph", 32'(pmu_periph_clk_en), 32'd1);
      req = 1'b0;
      step();
      req = 1'b1;
      lpmd = 2'b10;
      step();
      check("resleep_lpmd_st", 32'(pmu_lpmd_st), 32'd2);
      repeat (GD + 2) step();
      check("resleep_osc_pd", 32'(pmu_osc_pd), 32'd1);

      // async reset in the middle of a STOP wake
      irq = 1'b1;
      step();
      irq = 1'b0;
      repeat (3) step();
      check("pre_rst_in_wake", 32'(pmu_periph_clk_en), 32'd0);
      req = 1'b0;
      #2 pad_cpu_rst_b = 1'b0;
      #1;
      check("mid_rst_cpu_clk_en", 32'(pmu_cpu_clk_en), 32'd1);
      check("mid_rst_periph_clk_en", 32'(pmu_periph_clk_en), 32'd1);
      check("mid_rst_osc_pd", 32'(pmu_osc_pd), 32'd0);
      model_reset();
      #2 pad_cpu_rst_b = 1'b1;
      clr_track();
      repeat (20) step();
      check("post_rst_wake_cnt", 32'(wake_cnt), 32'd0);

      cyc = 0;
      clr_track();
      for (int i = 0; i < 3000; i++) begin
         if (ph == P_IDLE) begin
            if ($urandom % 8 == 0) cfg = 8'($urandom % 24);
            req = ($urandom % 4 == 0);
         end else if (ph == P_REL) begin
            req = ($urandom % 3 == 0);
         end else begin
            req = 1'b1;
         end
         irq  = ($urandom % 10 == 0);
         lpmd = 2'($urandom % 4);
         step();
      end
      check("rand_saw_wakeups", 32'(wake_cnt > 20), 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
